// File: rtl/decode_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : decode_stage
// Brief   : Handshaked IF->EX decode register with load scoreboard and hazard stall
// Revision: 1.0
//------------------------------------------------------------------------------

`ifndef OP_R
`define OP_R 0
`endif
`ifndef OP_B
`define OP_B 12
`endif
`ifndef R_FUNC_LD
`define R_FUNC_LD 8
`endif
`ifndef R_FUNC_ST
`define R_FUNC_ST 9
`endif

module decode_stage #(
  parameter int INST_W    = 16,
  parameter int OPCODE_W  = 4,
  parameter int R_FUNC_W  = 4,
  parameter int RF_ADDR_W = 3,
  parameter int IMM_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [INST_W-1:0]         if_inst,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [INST_W-1:0]         id_inst,
  output logic [RF_ADDR_W-1:0]      id_rd,
  output logic [RF_ADDR_W-1:0]      id_rs,
  output logic [IMM_W-1:0]          id_imm,
  output logic                      id_is_load,
  output logic                      id_is_store,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic [RF_ADDR_W-1:0]      wb_addr,
  output logic [2**RF_ADDR_W-1:0]   busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int NREG = 2**RF_ADDR_W;

  localparam logic [OPCODE_W-1:0] C_OP_R      = OPCODE_W'(`OP_R);
  localparam logic [OPCODE_W-1:0] C_OP_B      = OPCODE_W'(`OP_B);
  localparam logic [R_FUNC_W-1:0] C_FUNC_LD   = R_FUNC_W'(`R_FUNC_LD);
  localparam logic [R_FUNC_W-1:0] C_FUNC_ST   = R_FUNC_W'(`R_FUNC_ST);
  localparam logic [CNT_W-1:0]    C_CNT_MAX   = {CNT_W{1'b1}};

  logic [OPCODE_W-1:0]  w_opcode;
  logic [R_FUNC_W-1:0]  w_funct;
  logic [RF_ADDR_W-1:0] w_rd;
  logic [RF_ADDR_W-1:0] w_rs;
  logic [IMM_W-1:0]     w_imm;
  logic                 w_is_r;
  logic                 w_is_b;
  logic                 w_rd_hit;
  logic                 w_rs_hit;
  logic                 w_hazard;
  logic                 w_accept;
  logic                 w_handoff;
  logic                 w_stall;
  logic [NREG-1:0]      w_busy_nxt;

  assign w_opcode = if_inst[INST_W-1 -: OPCODE_W];
  assign w_funct  = if_inst[INST_W-OPCODE_W-1 -: R_FUNC_W];
  assign w_rd     = if_inst[RF_ADDR_W-1:0];
  assign w_rs     = if_inst[2*RF_ADDR_W-1:RF_ADDR_W];
  assign w_is_r   = (w_opcode == C_OP_R);
  assign w_is_b   = (w_opcode == C_OP_B);
  assign w_imm    = w_is_b ? if_inst[IMM_W-1:0] : if_inst[INST_W-OPCODE_W-1 -: IMM_W];

  // A load still sitting in the output register is as good as busy: its
  // scoreboard bit only appears once EX takes it.
  assign w_rd_hit = busy[w_rd] | (id_valid & id_is_load & (id_rd == w_rd));
  assign w_rs_hit = busy[w_rs] | (id_valid & id_is_load & (id_rd == w_rs));
  assign w_hazard = ~w_is_b & (w_rd_hit | (w_is_r & w_rs_hit));

  assign if_ready  = (~id_valid | id_ready) & ~w_hazard & ~flush;
  assign w_accept  = if_valid & if_ready;
  assign w_handoff = id_valid & id_ready;
  assign w_stall   = if_valid & w_hazard & ~flush;

  // Clear first, then set, so a newer load beats a write-back to the same register.
  always_comb begin
    w_busy_nxt = busy;
    if (wb_valid) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_handoff & id_is_load & ~flush) begin
      w_busy_nxt[id_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_inst     <= '0;
      id_rd       <= '0;
      id_rs       <= '0;
      id_imm      <= '0;
      id_is_load  <= 1'b0;
      id_is_store <= 1'b0;
      busy        <= '0;
      stall_cnt   <= '0;
    end else begin
      busy <= w_busy_nxt;
      if (flush) begin
        id_valid <= 1'b0;
      end else if (w_accept) begin
        id_valid    <= 1'b1;
        id_inst     <= if_inst;
        id_rd       <= w_rd;
        id_rs       <= w_rs;
        id_imm      <= w_imm;
        id_is_load  <= w_is_r & (w_funct == C_FUNC_LD);
        id_is_store <= w_is_r & (w_funct == C_FUNC_ST);
      end else if (w_handoff) begin
        id_valid <= 1'b0;
      end
      if (w_stall && (stall_cnt != C_CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_decode_stage
// Brief   : Scoreboard bench for decode_stage (handshake, hazards, flush, stall count)
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_decode_stage;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [15:0] inst;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [7:0]  imm;
    logic        ld;
    logic        st;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_inst;
  logic [2:0]  id_rd;
  logic [2:0]  id_rs;
  logic [7:0]  id_imm;
  logic        id_is_load;
  logic        id_is_store;
  logic        flush;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  busy;
  logic [CNT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  bundle_t q[$];

  decode_stage #(
    .INST_W(16), .OPCODE_W(4), .R_FUNC_W(4), .RF_ADDR_W(3), .IMM_W(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_rd(id_rd), .id_rs(id_rs), .id_imm(id_imm),
    .id_is_load(id_is_load), .id_is_store(id_is_store),
    .flush(flush), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bundle_t model(input logic [15:0] i);
    bundle_t b;
    b.inst = i;
    b.rd   = i[2:0];
    b.rs   = i[5:3];
    b.imm  = (i[15:12] == 4'hC) ? i[7:0] : i[11:4];
    b.ld   = (i[15:12] == 4'h0) && (i[11:8] == 4'h8);
    b.st   = (i[15:12] == 4'h0) && (i[11:8] == 4'h9);
    return b;
  endfunction

  function automatic logic [15:0] mk_r(input logic [3:0] f, input logic [2:0] rs, input logic [2:0] rd);
    return {4'h0, f, 2'b00, rs, rd};
  endfunction

  // Scoreboard: expected bundles enter on accept, leave on handoff or flush.
  always @(negedge clk) begin
    bundle_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (id_valid && (id_ready || flush)) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sb_underflow: id_inst=%h left stage with nothing expected", id_inst);
        end else begin
          e = q.pop_front();
          if (id_ready) begin
            n_vec++;
            if ({id_inst, id_rd, id_rs, id_imm, id_is_load, id_is_store} !== e) begin
              n_err++;
              $display("FAIL sb_bundle: got inst=%h rd=%0d rs=%0d imm=%h ld=%b st=%b, exp inst=%h rd=%0d rs=%0d imm=%h ld=%b st=%b",
                       id_inst, id_rd, id_rs, id_imm, id_is_load, id_is_store,
                       e.inst, e.rd, e.rs, e.imm, e.ld, e.st);
            end
          end
        end
      end
      if (if_valid && if_ready) q.push_back(model(if_inst));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b1; if_inst = mk_r(4'h1, 3'd1, 3'd1);
    id_ready = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
    #1;
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rst_held_if_ready: got %b exp 1", if_ready); end
    step(); step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_held_no_accept: id_valid got %b exp 0", id_valid); end
    rst_n = 1'b1; if_valid = 1'b0;
    step();
    // Build state: LD r3 outstanding, OP_B held in output, reader stalled 5 cycles
    if_valid = 1'b1; if_inst = mk_r(4'h8, 3'd0, 3'd3);
    step();
    if_inst = 16'hC05A;
    step();
    id_ready = 1'b0; if_inst = mk_r(4'h1, 3'd1, 3'd3);
    repeat (5) step();
    n_vec++; if (id_valid !== 1'b1 || busy !== 8'h08 || stall_cnt !== 4'd5) begin
      n_err++; $display("FAIL rst_pre_state: id_valid=%b busy=%h stall=%0d exp 1/08/5", id_valid, busy, stall_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({id_valid, id_inst, id_rd, id_rs, id_imm, id_is_load, id_is_store} !== '0 || busy !== 8'h00 || stall_cnt !== '0) begin
      n_err++; $display("FAIL rst_async_clear: id_valid=%b id_inst=%h busy=%h stall=%0d exp all 0", id_valid, id_inst, busy, stall_cnt);
    end
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL rst_async_if_ready: got %b exp 1", if_ready); end
    step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_async_no_accept: id_valid got %b exp 0", id_valid); end
    rst_n = 1'b1; if_valid = 1'b0; id_ready = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [15:0] insts [4];
    insts[0] = mk_r(4'h1, 3'd1, 3'd2);
    insts[1] = mk_r(4'h2, 3'd3, 3'd4);
    insts[2] = mk_r(4'h3, 3'd5, 3'd6);
    insts[3] = mk_r(4'h4, 3'd7, 3'd0);
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin if_valid = 1'b1; if_inst = insts[i]; end
      else if_valid = 1'b0;
      #1;
      if (i < 4) begin
        n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL stream_if_ready[%0d]: got %b exp 1", i, if_ready); end
      end
      step();
      n_vec++; if (id_valid !== (i < 4)) begin n_err++; $display("FAIL stream_id_valid[%0d]: got %b exp %b", i, id_valid, (i < 4)); end
      if (i < 4) begin
        n_vec++; if (id_inst !== insts[i]) begin n_err++; $display("FAIL stream_id_inst[%0d]: got %h exp %h", i, id_inst, insts[i]); end
      end
    end
    n_vec++; if (stall_cnt !== '0) begin n_err++; $display("FAIL stream_stall_cnt: got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    logic [CNT_W-1:0] s0;
    s0 = stall_cnt;
    id_ready = 1'b1; if_valid = 1'b1; if_inst = mk_r(4'h8, 3'd2, 3'd3);
    step();
    if_inst = mk_r(4'h1, 3'd1, 3'd3);
    #1;
    n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_inreg_if_ready: got %b exp 0", if_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (if_ready !== 1'b0 || busy[3] !== 1'b1) begin
        n_err++; $display("FAIL lu_stalled[%0d]: if_ready=%b busy3=%b exp 0/1", i, if_ready, busy[3]);
      end
    end
    step();
    wb_valid = 1'b1; wb_addr = 3'd3;
    #1;
    n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL lu_no_bypass: if_ready got %b exp 0", if_ready); end
    step();
    wb_valid = 1'b0;
    n_vec++; if (if_ready !== 1'b1 || busy[3] !== 1'b0) begin
      n_err++; $display("FAIL lu_after_wb: if_ready=%b busy3=%b exp 1/0", if_ready, busy[3]);
    end
    step();
    if_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b1 || id_inst !== mk_r(4'h1, 3'd1, 3'd3)) begin
      n_err++; $display("FAIL lu_add_accepted: id_valid=%b id_inst=%h exp 1/%h", id_valid, id_inst, mk_r(4'h1, 3'd1, 3'd3));
    end
    n_vec++; if (stall_cnt !== s0 + CNT_W'(5)) begin n_err++; $display("FAIL lu_stall_cnt: got %0d exp %0d", stall_cnt, s0 + CNT_W'(5)); end
    step();
  endtask

  task automatic test_inreg_hazard();
    id_ready = 1'b0; if_valid = 1'b1; if_inst = mk_r(4'h8, 3'd0, 3'd2);
    step();
    if_inst = 16'h3002;
    #1;
    n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL ir_if_ready_held: got %b exp 0", if_ready); end
    step();
    id_ready = 1'b1;
    #1;
    n_vec++; if (if_ready !== 1'b0 || id_inst !== mk_r(4'h8, 3'd0, 3'd2)) begin
      n_err++; $display("FAIL ir_if_ready_handoff: if_ready=%b id_inst=%h exp 0/%h", if_ready, id_inst, mk_r(4'h8, 3'd0, 3'd2));
    end
    step();
    n_vec++; if (busy[2] !== 1'b1 || id_valid !== 1'b0 || if_ready !== 1'b0) begin
      n_err++; $display("FAIL ir_busy_set: busy2=%b id_valid=%b if_ready=%b exp 1/0/0", busy[2], id_valid, if_ready);
    end
    wb_valid = 1'b1; wb_addr = 3'd2;
    step();
    wb_valid = 1'b0;
    step();
    if_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b1 || id_inst !== 16'h3002) begin
      n_err++; $display("FAIL ir_reader_accepted: id_valid=%b id_inst=%h exp 1/3002", id_valid, id_inst);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] x, y;
    x = mk_r(4'h2, 3'd4, 3'd5);
    y = mk_r(4'h3, 3'd6, 3'd7);
    id_ready = 1'b1; if_valid = 1'b1; if_inst = x;
    step();
    id_ready = 1'b0; if_inst = y;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_inst !== x || id_rd !== 3'd5 || id_rs !== 3'd4) begin
        n_err++; $display("FAIL bp_hold[%0d]: if_ready=%b id_valid=%b id_inst=%h rd=%0d rs=%0d exp 0/1/%h/5/4",
                          i, if_ready, id_valid, id_inst, id_rd, id_rs, x);
      end
      step();
    end
    id_ready = 1'b1;
    #1;
    n_vec++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_if_ready: got %b exp 1", if_ready); end
    step();
    if_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b1 || id_inst !== y) begin
      n_err++; $display("FAIL bp_next: id_valid=%b id_inst=%h exp 1/%h", id_valid, id_inst, y);
    end
    step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: id_valid got %b exp 0", id_valid); end
  endtask

  task automatic test_flush();
    logic [7:0] b0;
    id_ready = 1'b0; if_valid = 1'b1; if_inst = mk_r(4'h4, 3'd1, 3'd1);
    step();
    if_inst = mk_r(4'h5, 3'd2, 3'd4); flush = 1'b1;
    #1;
    b0 = busy;
    n_vec++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL fl_if_ready: got %b exp 0", if_ready); end
    step();
    flush = 1'b0; if_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b0 || busy !== b0) begin
      n_err++; $display("FAIL fl_kill: id_valid=%b busy=%h exp 0/%h", id_valid, busy, b0);
    end
    step();
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL fl_not_accepted: id_valid got %b exp 0", id_valid); end
    // Simultaneous write-back and load handoff to r5
    if_valid = 1'b1; if_inst = mk_r(4'h8, 3'd0, 3'd5);
    step();
    if_valid = 1'b0; id_ready = 1'b1; wb_valid = 1'b1; wb_addr = 3'd5;
    step();
    n_vec++; if (busy[5] !== 1'b1) begin n_err++; $display("FAIL fl_set_wins: busy5 got %b exp 1", busy[5]); end
    step();
    n_vec++; if (busy[5] !== 1'b0) begin n_err++; $display("FAIL fl_wb_clear: busy5 got %b exp 0", busy[5]); end
    wb_addr = 3'd6;
    step();
    wb_valid = 1'b0;
    n_vec++; if (busy !== 8'h00) begin n_err++; $display("FAIL fl_wb_noop: busy got %h exp 00", busy); end
  endtask

  task automatic test_stall_sat();
    logic [CNT_W-1:0] s0;
    int exp_cnt;
    id_ready = 1'b1; if_valid = 1'b1; if_inst = mk_r(4'h8, 3'd0, 3'd7);
    step();
    if_valid = 1'b0;
    step();
    s0 = stall_cnt;
    if_valid = 1'b1; if_inst = 16'h3007; flush = 1'b1;
    step(); step();
    n_vec++; if (stall_cnt !== s0) begin n_err++; $display("FAIL sat_flush_nocount: got %0d exp %0d", stall_cnt, s0); end
    flush = 1'b0;
    repeat (20) step();
    exp_cnt = (int'(s0) + 20 > 15) ? 15 : int'(s0) + 20;
    n_vec++; if (stall_cnt !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL sat_count: got %0d exp %0d", stall_cnt, exp_cnt); end
    wb_valid = 1'b1; wb_addr = 3'd7;
    step();
    wb_valid = 1'b0;
    step();
    if_valid = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_load_use();
    test_inreg_hazard();
    test_backpressure();
    test_flush();
    test_stall_sat();
    n_vec++;
    if (q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries exp 0", q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage between fetch (IF) and execute (EX).
- Parametrised in instruction, field, register-address and immediate widths.
- Extracts the operand fields and tracks outstanding loads in a per-register busy scoreboard.
- Stalls IF on load-use/WAW hazards, supports a flush on taken branch, and counts stall cycles.

Parameters:
INST_W, 16, instruction width
OPCODE_W, 4, opcode field width (MSBs)
R_FUNC_W, 4, R-type funct field width (directly below opcode)
RF_ADDR_W, 3, register address width; NREG = 2**RF_ADDR_W
IMM_W, 8, immediate width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
if_valid  in  1  IF holds an instruction
if_ready  out  1  stage accepts if_inst this cycle
if_inst  in  INST_W  instruction from fetch
id_valid  out  1  decoded bundle valid
id_ready  in  1  EX accepts bundle
id_inst  out  INST_W  registered raw instruction
id_rd  out  RF_ADDR_W  inst[RF_ADDR_W-1:0]
id_rs  out  RF_ADDR_W  inst[2*RF_ADDR_W-1:RF_ADDR_W]
id_imm  out  IMM_W  immediate
id_is_load  out  1  R-type with funct R_FUNC_LD
id_is_store  out  1  R-type with funct R_FUNC_ST
flush  in  1  taken branch; kill stage contents
wb_valid  in  1  load write-back completes
wb_addr  in  RF_ADDR_W  register written by completing load
busy  out  NREG  scoreboard bits (debug/verification)
stall_cnt  out  CNT_W  saturating hazard-stall count

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, async): id_valid=0; id_inst, id_rd, id_rs, id_imm, id_is_load, id_is_store=0; busy=0; stall_cnt=0.
- Field decode:
  - Encodings are the def.v macros (`OP_R, `OP_B, `R_FUNC_LD, `R_FUNC_ST).
  - opcode = inst[INST_W-1 -: OPCODE_W].
  - funct = inst[INST_W-OPCODE_W-1 -: R_FUNC_W].
  - id_imm = inst[IMM_W-1:0] when opcode==`OP_B, else inst[INST_W-OPCODE_W-1 -: IMM_W].
- Source usage:
  - `OP_R reads rd and rs.
  - `OP_B reads nothing.
  - All other opcodes read rd.
- Hazard (combinational on if_inst) = any read register that has either:
  - busy[r]=1, or
  - id_valid & id_is_load & id_rd==r (a load still in the output register).
- No bypass from wb_valid in the same cycle: a register cleared this cycle counts as busy until the next cycle.
- if_ready = (~id_valid | id_ready) & ~hazard & ~flush.
- Accept = if_valid & if_ready. On accept, all id_* fields load from if_inst and id_valid=1 next cycle. Latency 1 cycle.
- Handoff = id_valid & id_ready. Handoff without accept: id_valid=0 next cycle. Handoff with accept: back-to-back, no bubble.
- Output is held stable while id_valid & ~id_ready.
- flush: id_valid=0 next cycle and if_inst is not accepted. Busy bits are unaffected; loads already handed off still complete. flush takes priority over accept and hold.
- Scoreboard:
  - On handoff of a load with ~flush: busy[id_rd] <= 1.
  - On wb_valid: busy[wb_addr] <= 0.
  - Set and clear of the same register in one cycle: set wins (newer load).
  - wb_valid for a non-busy register is a no-op.
- stall_cnt increments when if_valid & hazard & ~flush and saturates at all-ones.
- A flush in the same cycle as a hazard does not count.
- The stage never holds more than one instruction.

Test Plan:
- Reset mid-operation: id_valid=1, busy=8'h08, stall_cnt=5, assert rst_n=0 asynchronously -> all outputs zero before the next clk edge. With reset held, if_ready=1 and nothing is accepted.
- Streaming: 4 back-to-back non-load `OP_R instructions with id_ready=1 -> id_valid high 4 cycles starting 1 cycle after the first accept. id_inst matches in order, stall_cnt=0.
- Load-use: LD r3 handed off, next instruction ADD r3,r1 -> if_ready=0 and busy[3]=1 until wb_valid with wb_addr=3. The ADD is accepted the cycle after write-back; stall_cnt equals the stalled cycles.
- In-register load hazard: LD r2 held in output with id_ready=0, if_inst reads r2 -> if_ready=0. Then id_ready=1 -> busy[2] set and the reader remains stalled.
- Backpressure: id_ready=0 for 3 cycles -> id_* stable, if_ready=0, no data loss.
- Flush: flush with id_valid=1 and if_valid=1 -> id_valid=0 next cycle, instruction not accepted, busy unchanged. wb_valid to r5 and a load-handoff to r5 in the same cycle -> busy[5]=1.
